treasure_reporter: RTL
======================

Name: treasure_reporter

Overview:
- Downstream of the camera capture/classification stage; consumes the 3-bit per-frame treasure code and a one-cycle frame-complete strobe.
- Applies a persistence filter: a code must repeat on STABLE_FRAMES consecutive frames before it is committed.
- Reports each committed change to the Arduino over a 4-phase REQ/ACK handshake, with a timeout so a dead Arduino link cannot hang the block.

Parameters:
STABLE_FRAMES, 3, consecutive identical frames required to commit a code (legal range 1..15)
TIMEOUT_CYCLES, 2500000, CLK cycles allowed per handshake phase before abort (100 ms at 25 MHz)
TO_W, 22, timeout counter width; must satisfy 2^TO_W >= TIMEOUT_CYCLES

Ports:
CLK  in  1  system clock (25 MHz VGA/processing clock)
RESET  in  1  synchronous, active-low reset
FRAME_VALID  in  1  one-cycle pulse; TREASURE_IN is valid on this cycle; already in the CLK domain
TREASURE_IN  in  3  per-frame classification (000 none, 010/011 tri B/R, 100/101 diamond B/R, 110/111 square B/R)
ACK  in  1  Arduino acknowledge; asynchronous, synchronised internally
TREASURE_OUT  out  3  code presented to the Arduino; held stable while REQ or the handshake is open
REQ  out  1  handshake request to the Arduino
STABLE_CODE  out  3  last committed code (debug/LED use)
BUSY  out  1  high when the FSM is not in IDLE
TIMEOUT_ERR  out  1  one-cycle pulse when a handshake phase is aborted

Behaviour:
Reset (RESET low at a CLK edge):
- All outputs go to 0.
- Internally: candidate=000, count=0, pending=0, ack_s pipeline=0, timer=0, FSM=IDLE.
- Reset asserted mid-handshake drops REQ at that edge; no completion is reported.

ACK synchronisation:
- Two-flop synchroniser produces ack_s.
- All FSM decisions use ack_s only, never raw ACK.

Persistence filter (acts only on cycles with FRAME_VALID=1):
- If TREASURE_IN==candidate: count <= min(count+1, STABLE_FRAMES).
- Otherwise: candidate <= TREASURE_IN and count <= 1.
- Commit condition: the new count equals STABLE_FRAMES, and the old count was < STABLE_FRAMES or the candidate just changed, and the candidate != STABLE_CODE.
- On commit: STABLE_CODE <= candidate and pending <= 1, both registered on the same edge.
- Saturation means a held code does not re-commit; it commits again only after a different code has intervened and then re-stabilised.
- 000 commits like any other code, so the Arduino is told when the treasure disappears.
- STABLE_FRAMES=1: every frame whose code differs from STABLE_CODE commits immediately.

Handshake FSM (states IDLE, REQ_HI, REQ_LO):
- IDLE: when pending=1 and ack_s=0, latch TREASURE_OUT <= STABLE_CODE, clear pending, assert REQ, clear timer, go to REQ_HI. If ack_s=1, wait in IDLE.
- REQ_HI: REQ=1. On ack_s=1, deassert REQ, clear timer, go to REQ_LO.
- REQ_LO: REQ=0. On ack_s=0, go to IDLE; the transaction is complete.
- TREASURE_OUT changes only on entry to REQ_HI; it is held at all other times, including in IDLE.

Timeout:
- The timer increments every cycle in REQ_HI and REQ_LO.
- When timer reaches TIMEOUT_CYCLES-1: pulse TIMEOUT_ERR, force REQ=0, go to IDLE.
- A timeout in REQ_HI also sets pending=1, so the latest STABLE_CODE is retried.
- A timeout in REQ_LO does not set pending.

Latency:
- FRAME_VALID that commits at edge t: STABLE_CODE valid after t; REQ high after t+1 (IDLE with ack_s=0).
- ACK rising: ack_s high 2 edges later; REQ falls on the following edge.

Simultaneous events:
- A commit while BUSY sets pending. Only the newest STABLE_CODE is sent after the current transaction; intermediate codes are dropped by design.
- A commit on the same edge that IDLE clears pending: the commit wins and pending stays 1.

Test Plan:
- Reset then 3 FRAME_VALID pulses with TREASURE_IN=3'b101, ACK tied 0 -> STABLE_CODE=101 after the 3rd pulse, REQ=1 one cycle later, TREASURE_OUT=101; after only 2 pulses, REQ stays 0.
- Frames 011,011,100,011,011,011 -> no commit until the 6th frame; STABLE_CODE=011 exactly once; a further 5 frames of 011 produce no new REQ.
- Full handshake: ACK raised 5 cycles after REQ and dropped 5 cycles after REQ falls -> REQ falls 3 cycles after ACK rises; BUSY drops 3 cycles after ACK falls; TIMEOUT_ERR never pulses.
- During an open handshake commit 110, then 000 -> after completion, exactly one new transaction with TREASURE_OUT=000.
- ACK never asserted, TIMEOUT_CYCLES=16 -> TIMEOUT_ERR pulses at REQ-high cycle 16, REQ drops, and REQ re-asserts with the same code on the next cycle (retry); in REQ_LO with ACK stuck high, TIMEOUT_ERR pulses and there is no retry.
- Assert RESET (low) while in REQ_HI -> REQ=0, TREASURE_OUT=000, STABLE_CODE=000 on that edge; a stable 3-frame code afterwards restarts reporting normally.

Source files
------------

// File: rtl/treasure_reporter.sv
// Persistence-filters the per-frame treasure code and reports each committed change
// to the Arduino over a 4-phase REQ/ACK handshake with a per-phase timeout.
module treasure_reporter #(
    parameter int STABLE_FRAMES  = 3,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int TO_W           = 22
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FRAME_VALID,
    input  logic [2:0] TREASURE_IN,
    input  logic       ACK,
    output logic [2:0] TREASURE_OUT,
    output logic       REQ,
    output logic [2:0] STABLE_CODE,
    output logic       BUSY,
    output logic       TIMEOUT_ERR
);

    // Handshake: REQ rises with TREASURE_OUT already stable; the Arduino raises ACK,
    // REQ then falls, the Arduino drops ACK, and only then is the transaction complete.
    typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

    localparam logic [3:0]      SF      = 4'(STABLE_FRAMES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    state_t          state_q, state_d;
    logic [2:0]      cand_q, cand_d;
    logic [3:0]      count_q, count_d;
    logic [2:0]      stable_q, stable_d;
    logic            pending_q, pending_d;
    logic            ack_meta_q, ack_meta_d;
    logic            ack_s_q, ack_s_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic [2:0]      tout_q, tout_d;
    logic            req_q, req_d;
    logic            err_q, err_d;
    logic            same;
    logic            commit;

    always_comb begin
        ack_meta_d = ACK;
        ack_s_d    = ack_meta_q;

        cand_d   = cand_q;
        count_d  = count_q;
        stable_d = stable_q;
        same     = (TREASURE_IN == cand_q);
        commit   = 1'b0;
        if (FRAME_VALID) begin
            if (same) begin
                count_d = (count_q >= SF) ? SF : count_q + 4'd1;
            end else begin
                cand_d  = TREASURE_IN;
                count_d = 4'd1;
            end
            // Saturation stops a held code from re-committing every frame.
            commit = (count_d == SF) && ((count_q < SF) || !same)
                     && (TREASURE_IN != stable_q);
        end
        if (commit) stable_d = TREASURE_IN;

        state_d   = state_q;
        req_d     = req_q;
        tout_d    = tout_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q && !ack_s_q) begin
                    tout_d    = stable_q;
                    pending_d = 1'b0;
                    req_d     = 1'b1;
                    timer_d   = '0;
                    state_d   = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s_q) begin
                    req_d   = 1'b0;
                    timer_d = '0;
                    state_d = REQ_LO;
                end else if (timer_q == TO_LAST) begin
                    err_d     = 1'b1;
                    req_d     = 1'b0;
                    pending_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TO_ONE;
                end
            end
            REQ_LO: begin
                if (!ack_s_q) begin
                    state_d = IDLE;
                end else if (timer_q == TO_LAST) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TO_ONE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        // A commit landing on the launch edge must not be lost.
        if (commit) pending_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= IDLE;
            cand_q     <= 3'b000;
            count_q    <= 4'd0;
            stable_q   <= 3'b000;
            pending_q  <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            timer_q    <= '0;
            tout_q     <= 3'b000;
            req_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            count_q    <= count_d;
            stable_q   <= stable_d;
            pending_q  <= pending_d;
            ack_meta_q <= ack_meta_d;
            ack_s_q    <= ack_s_d;
            timer_q    <= timer_d;
            tout_q     <= tout_d;
            req_q      <= req_d;
            err_q      <= err_d;
        end
    end

    assign TREASURE_OUT = tout_q;
    assign REQ          = req_q;
    assign STABLE_CODE  = stable_q;
    assign BUSY         = (state_q != IDLE);
    assign TIMEOUT_ERR  = err_q;

endmodule
